// File: rtl/nvram_uploader.sv
// nvram_uploader
// ---------------------------------------------------------------------------
// Read-side responder for the HPS ioctl upload stream. Each accepted upload
// read request fetches one byte from the CMOS/high-score NVRAM through port B
// of the board's dual-port RAM and returns it on ioctl_din. ioctl_wait is held
// high until the byte is valid. Requests beyond the NVRAM size are answered
// from the FILL path without touching the RAM. A dirty flag tracks CPU writes
// so the OSD can offer a save.
//
// Optional feature (macro NVRAM_CHECKSUM_EN):
//   An 8-bit running sum of the bytes served in the current session is kept.
//   A read at address N returns the two's complement of that sum, so the saved
//   file sums to 0x00. Without the macro, address N returns 0x00.
//
// Parameters:
//   ADDR_W       NVRAM address width, N = 2^ADDR_W bytes
//   UPLOAD_INDEX ioctl_index value selecting the NVRAM upload
//   RD_LAT       port-B read latency in clk_sys cycles (1..3)
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ioctl_upload upload session active
//   ioctl_index  target index of the current session
//   ioctl_rd     one-cycle read request strobe
//   ioctl_addr   byte address of the request
//   ioctl_din    returned byte
//   ioctl_wait   high while a read is in progress
//   nv_addr      NVRAM port-B address
//   nv_rd        NVRAM port-B read enable (one cycle)
//   nv_q         NVRAM port-B data, valid RD_LAT cycles after nv_rd
//   cpu_nv_we    CPU NVRAM write strobe
//   nv_dirty     NVRAM changed since the last completed upload
//   upload_done  one-cycle pulse at the end of a matching session
// ---------------------------------------------------------------------------
module nvram_uploader #(
  parameter int          ADDR_W       = 8,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int          RD_LAT       = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_rd,
  input  logic [7:0]        nv_q,
  input  logic              cpu_nv_we,
  output logic              nv_dirty,
  output logic              upload_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAT     = 2'd1,
    PRESENT = 2'd2,
    FILL    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] nv_addr_q, nv_addr_d;
  logic              nv_rd_q, nv_rd_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              upload_prev_q;
  logic              upload_done_q, upload_done_d;
  logic              dirty_q, dirty_d;
  logic              sess_we_q, sess_we_d;

  logic index_match;
  logic accept;
  logic in_range;
  logic sess_rise;
  logic sess_fall;
  logic lat_last;
  logic [7:0] fill_byte;

  assign index_match = (ioctl_index == UPLOAD_INDEX);
  assign accept      = ioctl_rd && ioctl_upload && index_match && (state_q == IDLE);
  // Address is below N exactly when every bit above the NVRAM width is zero.
  assign in_range    = (ioctl_addr[24:ADDR_W] == '0);
  assign sess_rise   = ioctl_upload && !upload_prev_q && index_match;
  assign sess_fall   = !ioctl_upload && upload_prev_q && index_match;
  assign lat_last    = (lat_cnt_q == 2'(RD_LAT - 1));

`ifdef NVRAM_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       fill_n_q, fill_n_d;

  // Running sum of served bytes; restarts with each matching session. The
  // FILL target is latched at accept so FILL knows whether it answers address N.
  always_comb begin
    sum_d    = sum_q;
    fill_n_d = fill_n_q;
    if (sess_rise) begin
      sum_d = 8'h00;
    end else if (state_q == PRESENT) begin
      sum_d = sum_q + nv_q;
    end
    if (accept) begin
      fill_n_d = (ioctl_addr == (25'(1) << ADDR_W));
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q    <= 8'h00;
      fill_n_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      fill_n_q <= fill_n_d;
    end
  end

  assign fill_byte = fill_n_q ? (~sum_q + 8'd1) : 8'h00;
`else
  assign fill_byte = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_range ? LAT : FILL;
        end
      end
      LAT: begin
        if (lat_last) begin
          state_d = PRESENT;
        end
      end
      PRESENT: state_d = IDLE;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. nv_rd defaults low so it can only pulse
  // on the IDLE to LAT transition.
  always_comb begin
    din_d     = din_q;
    wait_d    = wait_q;
    nv_addr_d = nv_addr_q;
    nv_rd_d   = 1'b0;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wait_d = 1'b1;
          if (in_range) begin
            nv_addr_d = ioctl_addr[ADDR_W-1:0];
            nv_rd_d   = 1'b1;
            lat_cnt_d = 2'd0;
          end
        end
      end
      LAT: begin
        lat_cnt_d = lat_cnt_q + 2'd1;
      end
      PRESENT: begin
        din_d  = nv_q;
        wait_d = 1'b0;
      end
      FILL: begin
        din_d  = fill_byte;
        wait_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Session tracking and dirty flag. A CPU write seen during a session keeps
  // the flag set through that session's end; a write coinciding with the
  // end-of-session clear wins over the clear.
  always_comb begin
    upload_done_d = sess_fall;

    sess_we_d = sess_we_q;
    if (cpu_nv_we && (ioctl_upload || upload_prev_q)) begin
      sess_we_d = 1'b1;
    end else if (sess_rise) begin
      sess_we_d = 1'b0;
    end

    dirty_d = dirty_q;
    if (cpu_nv_we) begin
      dirty_d = 1'b1;
    end else if (upload_done_q && !sess_we_q) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      din_q         <= 8'h00;
      wait_q        <= 1'b0;
      nv_addr_q     <= '0;
      nv_rd_q       <= 1'b0;
      lat_cnt_q     <= 2'd0;
      upload_prev_q <= 1'b0;
      upload_done_q <= 1'b0;
      dirty_q       <= 1'b0;
      sess_we_q     <= 1'b0;
    end else begin
      din_q         <= din_d;
      wait_q        <= wait_d;
      nv_addr_q     <= nv_addr_d;
      nv_rd_q       <= nv_rd_d;
      lat_cnt_q     <= lat_cnt_d;
      upload_prev_q <= ioctl_upload;
      upload_done_q <= upload_done_d;
      dirty_q       <= dirty_d;
      sess_we_q     <= sess_we_d;
    end
  end

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign nv_addr     = nv_addr_q;
  assign nv_rd       = nv_rd_q;
  assign nv_dirty    = dirty_q;
  assign upload_done = upload_done_q;

endmodule

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Read-side responder for the HPS ioctl upload stream: on each upload read request it fetches one byte from the game's CMOS/high-score NVRAM and returns it on ioctl_din, holding ioctl_wait until the byte is valid.
- Sits in emu between hps_io (upload direction) and port B of the mylstar_board NVRAM dual-port RAM.
- Also tracks a dirty flag from CPU NVRAM writes so the OSD can offer a save.

Parameters:
- ADDR_W, 8: NVRAM address width; NVRAM size N = 2^ADDR_W bytes.
- UPLOAD_INDEX, 4: ioctl_index value that selects NVRAM upload.
- RD_LAT, 1: NVRAM port-B read latency in clk_sys cycles (1..3).

Ports:
- clk_sys, in, 1: system clock, 50 MHz.
- reset_n, in, 1: asynchronous active-low reset.
- ioctl_upload, in, 1: upload session active.
- ioctl_index, in, 8: target index of the current session.
- ioctl_rd, in, 1: one-cycle read request strobe.
- ioctl_addr, in, 25: byte address of the request.
- ioctl_din, out, 8: returned byte.
- ioctl_wait, out, 1: high while a read is in progress.
- nv_addr, out, ADDR_W: NVRAM port-B address.
- nv_rd, out, 1: NVRAM port-B read enable, one cycle.
- nv_q, in, 8: NVRAM port-B data, valid RD_LAT cycles after nv_rd.
- cpu_nv_we, in, 1: CPU NVRAM write strobe (clk_sys domain).
- nv_dirty, out, 1: NVRAM changed since the last completed upload.
- upload_done, out, 1: one-cycle pulse at the end of a matching session.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; ioctl_din=0x00; ioctl_wait=0; nv_addr=0; nv_rd=0; nv_dirty=0; upload_done=0; internal latency counter=0.
- A request is accepted when ioctl_rd=1, ioctl_upload=1, ioctl_index==UPLOAD_INDEX and the FSM is in IDLE. ioctl_rd in any other state, or with the wrong index, or with upload low is ignored. No queueing.
- IDLE:
  - Accepted request with ioctl_addr < N: register nv_addr=ioctl_addr[ADDR_W-1:0], pulse nv_rd, set ioctl_wait=1, go to LAT.
  - Accepted request with ioctl_addr >= N: set ioctl_wait=1, go to FILL. No RAM access.
- LAT: count RD_LAT cycles from the nv_rd edge; on the last count go to PRESENT.
- PRESENT: ioctl_din<=nv_q, ioctl_wait<=0 on the same edge, go to IDLE.
- FILL: ioctl_din<=0x00, ioctl_wait<=0, go to IDLE.
- Latency: ioctl_wait rises on the edge after the accepted rd. In-range reads take RD_LAT+1 cycles from that edge to ioctl_wait falling. Out-of-range reads take 1 cycle.
- ioctl_din holds its value until the next completed read.
- nv_rd is never asserted outside IDLE→LAT.
- Session end: upload_done pulses for one cycle on the falling edge of ioctl_upload while ioctl_index==UPLOAD_INDEX.
  - If the fall happens mid-read, the FSM still completes the read; upload_done is not delayed by it.
- Dirty flag:
  - cpu_nv_we=1 sets nv_dirty.
  - upload_done clears nv_dirty, unless cpu_nv_we was seen at any point during the session; then it stays 1.
  - Same-cycle set and clear: set wins.
- Address uses ioctl_addr only. No internal auto-increment. No wrap: addresses >= N always go to FILL.
- A new session (rising edge of ioctl_upload) does not reset ioctl_din.

Optional Feature:
- Macro: NVRAM_CHECKSUM_EN.
- Defined:
  - An 8-bit sum accumulator clears on the rising edge of a matching ioctl_upload.
  - Each PRESENT adds the served byte to it (mod 256).
  - A read at ioctl_addr == N returns (~sum + 1) & 0xFF via the FILL path (1 cycle), so the saved file sums to 0x00.
  - Addresses > N return 0x00.
- Undefined: no accumulator; address N returns 0x00 like any other out-of-range address.

Test Plan:
- Preload NVRAM[0x10]=0xA5, RD_LAT=1; upload index 4; rd at addr 0x10 → nv_rd one cycle with nv_addr=0x10; ioctl_wait high for exactly 2 cycles; ioctl_din=0xA5 as ioctl_wait falls.
- rd at addr 0x100 (N=256) → no nv_rd; ioctl_wait high 1 cycle; ioctl_din=0x00; with NVRAM_CHECKSUM_EN after reading bytes 0x01,0x02,0x03 → 0xFA.
- rd with ioctl_index=0, or rd during ioctl_wait=1 → ignored: no nv_rd, ioctl_din unchanged.
- cpu_nv_we pulse → nv_dirty=1; full upload ends → upload_done pulse, nv_dirty=0; repeat with a cpu_nv_we pulse mid-session → nv_dirty stays 1; cpu_nv_we in the same cycle as upload_done → nv_dirty=1.
- Drop ioctl_upload during LAT → read completes with correct ioctl_din; upload_done pulses once.
- Assert reset_n=0 during LAT → ioctl_wait, nv_rd, nv_dirty go 0 immediately and ioctl_din=0x00; after release the next valid rd is served normally.
